// File: rtl/inst_rom_resp_if.sv
// ============================================================================
// inst_rom_resp_if : fetch port and byte-serial loader bundle for inst_rom_resp
// Rev 1.0
// ============================================================================
`default_nettype none

interface inst_rom_resp_if;
    logic        inst_rom_ce_i;
    logic [31:0] inst_rom_addr_i;
    logic [31:0] inst_rom_data_o;
    logic        inst_rom_valid_o;
    logic        inst_rom_misalign_o;
    logic        inst_rom_range_o;
    logic        load_start_i;
    logic [7:0]  load_byte_i;
    logic        load_valid_i;
    logic        load_last_i;
    logic        load_ready_o;
    logic        load_done_o;
    logic        load_ovf_o;
    logic        parity_err_o;

    modport master (
        output inst_rom_ce_i, inst_rom_addr_i,
        output load_start_i, load_byte_i, load_valid_i, load_last_i,
        input  inst_rom_data_o, inst_rom_valid_o, inst_rom_misalign_o, inst_rom_range_o,
        input  load_ready_o, load_done_o, load_ovf_o, parity_err_o
    );

    modport slave (
        input  inst_rom_ce_i, inst_rom_addr_i,
        input  load_start_i, load_byte_i, load_valid_i, load_last_i,
        output inst_rom_data_o, inst_rom_valid_o, inst_rom_misalign_o, inst_rom_range_o,
        output load_ready_o, load_done_o, load_ovf_o, parity_err_o
    );
endinterface

`default_nettype wire

// File: rtl/inst_rom_resp.sv
// ============================================================================
// inst_rom_resp : instruction ROM responder, big-endian byte-serial loader,
//                 1-cycle fetch with misalign/range flags.
//                 Optional stored parity: define INST_ROM_PARITY_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module inst_rom_resp #(
    parameter int ADDR_W = 10
) (
    input  logic            clk,
    input  logic            rst,
    inst_rom_resp_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W:0]   ptr;
    logic [1:0]        byte_cnt;
    logic [31:0]       word_buf;
    logic              ovf;

    logic              accept;
    logic              in_range;
    logic              wr_en;
    logic [4:0]        shift;
    logic [31:0]       wr_word;

    logic [31:0]       mem [0:DEPTH-1];

    logic [ADDR_W-1:0] rd_idx;
    logic              misalign;
    logic              out_of_range;

    logic [31:0]       rsp_data;
    logic              rsp_valid;
    logic              rsp_misalign;
    logic              rsp_range;

    // Start has priority over a byte offered in the same cycle.
    always_comb begin
        accept    = bus.load_valid_i && (state == ST_LOAD) && !bus.load_start_i;
        in_range  = !ptr[ADDR_W];
        shift     = {2'd3 - byte_cnt, 3'b000};
        wr_word   = word_buf | ({24'd0, bus.load_byte_i} << shift);
        wr_en     = accept && in_range && ((byte_cnt == 2'd3) || bus.load_last_i);
        state_nxt = state;
        case (state)
            ST_LOAD: if (accept && bus.load_last_i) state_nxt = ST_RUN;
            ST_RUN:  if (bus.load_start_i)          state_nxt = ST_LOAD;
            default: state_nxt = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_LOAD;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr      <= '0;
            byte_cnt <= 2'd0;
            word_buf <= 32'd0;
            ovf      <= 1'b0;
        end else if (bus.load_start_i) begin
            ptr      <= '0;
            byte_cnt <= 2'd0;
            word_buf <= 32'd0;
            ovf      <= 1'b0;
        end else if (accept) begin
            if (!in_range) begin
                ovf      <= 1'b1;
                byte_cnt <= 2'd0;
                word_buf <= 32'd0;
            end else if (wr_en) begin
                ptr      <= ptr + 1'b1;
                byte_cnt <= 2'd0;
                word_buf <= 32'd0;
            end else begin
                byte_cnt <= byte_cnt + 2'd1;
                word_buf <= wr_word;
            end
        end
    end

    // Program store is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[ptr[ADDR_W-1:0]] <= wr_word;
    end

    always_comb begin
        rd_idx       = bus.inst_rom_addr_i[ADDR_W+1:2];
        misalign     = |bus.inst_rom_addr_i[1:0];
        out_of_range = |(bus.inst_rom_addr_i >> (ADDR_W + 2));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_data     <= 32'd0;
            rsp_valid    <= 1'b0;
            rsp_misalign <= 1'b0;
            rsp_range    <= 1'b0;
        end else begin
            rsp_data     <= 32'd0;
            rsp_valid    <= 1'b0;
            rsp_misalign <= 1'b0;
            rsp_range    <= 1'b0;
            if ((state == ST_RUN) && bus.inst_rom_ce_i) begin
                rsp_valid <= 1'b1;
                if (misalign)          rsp_misalign <= 1'b1;
                else if (out_of_range) rsp_range    <= 1'b1;
                else                   rsp_data     <= mem[rd_idx];
            end
        end
    end

`ifdef INST_ROM_PARITY_EN
    logic par_mem [0:DEPTH-1];
    logic rsp_par;

    always_ff @(posedge clk) begin
        if (wr_en) par_mem[ptr[ADDR_W-1:0]] <= ^wr_word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_par <= 1'b0;
        end else begin
            rsp_par <= 1'b0;
            if ((state == ST_RUN) && bus.inst_rom_ce_i && !misalign && !out_of_range)
                rsp_par <= (^mem[rd_idx]) ^ par_mem[rd_idx];
        end
    end

    assign bus.parity_err_o = rsp_par;
`else
    assign bus.parity_err_o = 1'b0;
`endif

    assign bus.inst_rom_data_o     = rsp_data;
    assign bus.inst_rom_valid_o    = rsp_valid;
    assign bus.inst_rom_misalign_o = rsp_misalign;
    assign bus.inst_rom_range_o    = rsp_range;
    assign bus.load_ready_o        = (state == ST_LOAD);
    assign bus.load_done_o         = (state == ST_RUN);
    assign bus.load_ovf_o          = ovf;

endmodule

`default_nettype wire
